// File: rtl/f2i_if.sv
// Shared width/bias constants and the operand/result interface of the f2i converter.
package f2i_pkg;
  localparam int unsigned EXP_WIDTH   = 8;
  localparam int unsigned FRACT_WIDTH = 7;
  localparam int unsigned BIAS        = 127;
endpackage

interface f2i_if;
  logic                             valid_f2i_i;
  logic                             sgn_i;
  logic [f2i_pkg::EXP_WIDTH-1:0]   exp_i;
  logic [f2i_pkg::FRACT_WIDTH-1:0] fract_i;
  logic [f2i_pkg::EXP_WIDTH-1:0]   integer_o;
  logic [f2i_pkg::FRACT_WIDTH-1:0] fract_o;
  logic                             valid_f2i_o;
  logic                             busy_o;

  modport master (
    output valid_f2i_i, sgn_i, exp_i, fract_i,
    input  integer_o, fract_o, valid_f2i_o, busy_o
  );

  modport slave (
    input  valid_f2i_i, sgn_i, exp_i, fract_i,
    output integer_o, fract_o, valid_f2i_o, busy_o
  );
endinterface

// File: rtl/f2i.sv
// Iterative float-to-fixed converter: one shift per cycle, then sign, then registered result.
// Optional macro F2I_ROUND_EN keeps a guard bit on right shifts and rounds half up on magnitude.
module f2i
  import f2i_pkg::*;
(
  input  logic clk,
  input  logic rst,
  f2i_if.slave bus
);

  localparam int unsigned FIX_W = EXP_WIDTH + FRACT_WIDTH;
  localparam int unsigned CNT_W = $clog2(FRACT_WIDTH + 2);
  localparam int unsigned E_W   = EXP_WIDTH + 2;

  localparam logic signed [E_W-1:0] BIAS_S    = E_W'(BIAS);
  localparam logic signed [E_W-1:0] E_SAT     = E_W'(EXP_WIDTH - 1);
  localparam logic signed [E_W-1:0] E_MIN     = E_W'(-(FRACT_WIDTH + 1));
  localparam logic [CNT_W-1:0]      CLAMP_CNT = CNT_W'(FRACT_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    SIGN,
    DONE
  } state_t;

  state_t                 state_q, state_nxt;
  logic [FIX_W-1:0]       acc_q, acc_nxt;
  logic [CNT_W-1:0]       cnt_q, cnt_nxt;
  logic                   left_q, left_nxt;
  logic                   sgn_q, sgn_nxt;
  logic                   sat_q, sat_nxt;
  logic [EXP_WIDTH-1:0]   int_q, int_nxt;
  logic [FRACT_WIDTH-1:0] frc_q, frc_nxt;
  logic                   valid_q, valid_nxt;
`ifdef F2I_ROUND_EN
  logic                   guard_q, guard_nxt;
`endif

  logic signed [E_W-1:0]  e_in;
  logic [E_W-1:0]         e_mag;
  logic [FIX_W-1:0]       mag;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      left_q  <= 1'b0;
      sgn_q   <= 1'b0;
      sat_q   <= 1'b0;
      int_q   <= '0;
      frc_q   <= '0;
      valid_q <= 1'b0;
`ifdef F2I_ROUND_EN
      guard_q <= 1'b0;
`endif
    end else begin
      state_q <= state_nxt;
      acc_q   <= acc_nxt;
      cnt_q   <= cnt_nxt;
      left_q  <= left_nxt;
      sgn_q   <= sgn_nxt;
      sat_q   <= sat_nxt;
      int_q   <= int_nxt;
      frc_q   <= frc_nxt;
      valid_q <= valid_nxt;
`ifdef F2I_ROUND_EN
      guard_q <= guard_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state_q;
    acc_nxt   = acc_q;
    cnt_nxt   = cnt_q;
    left_nxt  = left_q;
    sgn_nxt   = sgn_q;
    sat_nxt   = sat_q;
    int_nxt   = int_q;
    frc_nxt   = frc_q;
    valid_nxt = 1'b0;
`ifdef F2I_ROUND_EN
    guard_nxt = guard_q;
    mag       = acc_q + FIX_W'(guard_q);
`else
    mag       = acc_q;
`endif
    e_in  = $signed({2'b00, bus.exp_i}) - BIAS_S;
    e_mag = e_in[E_W-1] ? $unsigned(-e_in) : $unsigned(e_in);

    unique case (state_q)
      IDLE: begin
        if (bus.valid_f2i_i) begin
          sgn_nxt  = bus.sgn_i;
          left_nxt = (e_in > 0);
          sat_nxt  = 1'b0;
          acc_nxt  = {{(EXP_WIDTH-1){1'b0}}, 1'b1, bus.fract_i};
          cnt_nxt  = CNT_W'(e_mag);
`ifdef F2I_ROUND_EN
          guard_nxt = 1'b0;
`endif
          if (bus.exp_i == '0) begin
            acc_nxt = '0;
            cnt_nxt = '0;
          end else if (bus.exp_i == '1 || e_in >= E_SAT) begin
            // Saturated value is final: SIGN leaves it untouched.
            sat_nxt = 1'b1;
            cnt_nxt = '0;
            acc_nxt = bus.sgn_i ? {1'b1, {(FIX_W-1){1'b0}}} : {1'b0, {(FIX_W-1){1'b1}}};
          end else if (e_in < E_MIN) begin
            // Too small to reach any output bit; shifting zero keeps latency and guard at 0.
            acc_nxt = '0;
            cnt_nxt = CLAMP_CNT;
          end
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q != '0) begin
          if (left_q) begin
            acc_nxt = acc_q << 1;
          end else begin
            acc_nxt = acc_q >> 1;
`ifdef F2I_ROUND_EN
            guard_nxt = acc_q[0];
`endif
          end
          cnt_nxt = cnt_q - CNT_W'(1);
        end else begin
          state_nxt = SIGN;
        end
      end
      SIGN: begin
        if (!sat_q) begin
          acc_nxt = sgn_q ? (FIX_W'(0) - mag) : mag;
        end
        state_nxt = DONE;
      end
      DONE: begin
        int_nxt   = acc_q[FIX_W-1:FRACT_WIDTH];
        frc_nxt   = acc_q[FRACT_WIDTH-1:0];
        valid_nxt = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.integer_o   = int_q;
  assign bus.fract_o     = frc_q;
  assign bus.valid_f2i_o = valid_q;
  assign bus.busy_o      = (state_q != IDLE);

endmodule

// File: doc/f2i.md
F2I -- requirements
Module: f2i

Interface
REQ-001 SHALL use package constant EXP_WIDTH, default 8, as the width of the exponent and of the integer part.
REQ-002 SHALL use package constant FRACT_WIDTH, default 7, as the width of the mantissa and of the fractional part.
REQ-003 SHALL use package constant BIAS, default 127, as the exponent bias.
REQ-004 SHALL have the port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have the port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have the port valid_f2i_i, input, 1 bit: input operand valid.
REQ-007 SHALL have the port sgn_i, input, 1 bit: float sign.
REQ-008 SHALL have the port exp_i, input, EXP_WIDTH bits: biased exponent.
REQ-009 SHALL have the port fract_i, input, FRACT_WIDTH bits: mantissa without the hidden 1.
REQ-010 SHALL have the port integer_o, output, EXP_WIDTH bits: integer part, two's complement.
REQ-011 SHALL have the port fract_o, output, FRACT_WIDTH bits: fraction bits below the binary point.
REQ-012 SHALL have the port valid_f2i_o, output, 1 bit: result valid, one-cycle pulse.
REQ-013 SHALL have the port busy_o, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-014 SHALL produce the result as {integer_o,fract_o}, a 15-bit two's-complement fixed-point value equal to (-1)^sgn * 1.fract * 2^(exp-BIAS).
REQ-015 SHALL implement the FSM states IDLE, SHIFT, SIGN and DONE.
REQ-016 IDLE: on valid_f2i_i=1, SHALL load acc={7'b0,1'b1,fract_i}, latch sgn_i, set e=exp_i-BIAS and cnt=|e|, then go to SHIFT.
REQ-017 IDLE: a cycle with valid_f2i_i=0 SHALL leave the state in IDLE.
REQ-018 SHIFT: while cnt!=0, SHALL shift acc left 1 bit if e>0 or right 1 bit if e<0, and decrement cnt. When cnt==0, SHALL go to SIGN.
REQ-019 SIGN: SHALL negate acc (two's complement) when the latched sign is 1, then go to DONE.
REQ-020 DONE: SHALL register acc onto integer_o/fract_o, pulse valid_f2i_o for exactly one cycle, and return to IDLE.
REQ-021 SHALL have a latency from the accept edge to valid_f2i_o of cnt+3 cycles; the maximum is 11.
REQ-022 SHALL clamp right shifts to cnt=8 when e<-8; the result is 0.
REQ-023 When exp_i==0 (zero or denormal), SHALL force acc=0 and cnt=0, giving latency 3.
REQ-024 When e>=7 or exp_i==255 (overflow, Inf or NaN), SHALL saturate with cnt=0:
  - sign 0 -> integer_o=8'h7F, fract_o=7'h7F
  - sign 1 -> integer_o=8'h80, fract_o=7'h00
REQ-025 SHALL ignore valid_f2i_i while busy_o=1: no queueing, and the in-flight operation is undisturbed.
REQ-026 SHALL hold integer_o and fract_o stable after DONE until the next DONE.
REQ-027 When a new valid_f2i_i arrives in the same cycle that DONE returns to IDLE, SHALL ignore it, because the accept happens only in IDLE.

Reset
REQ-028 SHALL, while rst=0, immediately force state=IDLE, acc=0, cnt=0, integer_o=0, fract_o=0, valid_f2i_o=0 and busy_o=0.
REQ-029 SHALL abort any operation in progress on a mid-operation reset without producing a valid pulse; the first accept is possible on the first rising edge after rst returns to 1.

Configuration
REQ-030 SHALL provide the macro F2I_ROUND_EN.
  - Defined: during right shifts, keep the last bit shifted out as a guard bit; in SIGN, add the guard bit to the magnitude before negation (round half up on magnitude). Latency is unchanged.
  - Undefined: truncate the magnitude toward zero; no guard bit is kept.

Verification
REQ-031 SHALL pass: sgn=0, exp=127, fract=0x00 -> integer_o=0x01, fract_o=0x00, valid 3 cycles after accept.
REQ-032 SHALL pass: sgn=0, exp=129, fract=0x40 (6.0) -> integer_o=0x06, fract_o=0x00, latency 5.
REQ-033 SHALL pass: sgn=1, exp=126, fract=0x00 (-0.5) -> integer_o=0xFF, fract_o=0x40, latency 4.
REQ-034 SHALL pass the saturation cases:
  - exp=134, sgn=0 -> 0x7F/0x7F, latency 3
  - exp=134, sgn=1 -> 0x80/0x00, latency 3
  - exp=0 -> 0x00/0x00, latency 3
REQ-035 SHALL pass: sgn=0, exp=119, fract=0x00 (2^-8) -> fract_o=0x01 with F2I_ROUND_EN, 0x00 without it; latency 11.
REQ-036 SHALL pass: a second valid pulse during SHIFT is ignored, and rst=0 asserted during SHIFT gives all outputs 0 with no valid pulse.
